// File: rtl/operand_fetch.sv
// Operand fetch stage: latches a request, reads the registered register file,
// merges in-flight writebacks, and holds the operands until downstream accepts.
module operand_fetch #(
    parameter int unsigned DATA_WIDTH_P    = 32,
    parameter int unsigned ADDR_WIDTH_P    = 5,
    parameter int unsigned PAYLOAD_WIDTH_P = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    // upstream request
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [ADDR_WIDTH_P-1:0]    i_rs1_addr,
    input  logic [ADDR_WIDTH_P-1:0]    i_rs2_addr,
    input  logic [ADDR_WIDTH_P-1:0]    i_rd_addr,
    input  logic [PAYLOAD_WIDTH_P-1:0] i_payload,
    // register file read port (registered, one-cycle latency)
    output logic [ADDR_WIDTH_P-1:0]    o_rf_rd_addr_a,
    output logic [ADDR_WIDTH_P-1:0]    o_rf_rd_addr_b,
    input  logic [DATA_WIDTH_P-1:0]    i_rf_rd_data_a,
    input  logic [DATA_WIDTH_P-1:0]    i_rf_rd_data_b,
    // writeback snoop
    input  logic                       i_wb_valid,
    input  logic [ADDR_WIDTH_P-1:0]    i_wb_addr,
    input  logic [DATA_WIDTH_P-1:0]    i_wb_data,
    // downstream
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [DATA_WIDTH_P-1:0]    o_rs1_data,
    output logic [DATA_WIDTH_P-1:0]    o_rs2_data,
    output logic [ADDR_WIDTH_P-1:0]    o_rd_addr,
    output logic [PAYLOAD_WIDTH_P-1:0] o_payload
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_OUT     = 2'd3;

    logic [1:0]                 state_q,    state_d;
    logic [ADDR_WIDTH_P-1:0]    rs1_q,      rs1_d;
    logic [ADDR_WIDTH_P-1:0]    rs2_q,      rs2_d;
    logic [ADDR_WIDTH_P-1:0]    rd_q,       rd_d;
    logic [PAYLOAD_WIDTH_P-1:0] payload_q,  payload_d;
    logic [DATA_WIDTH_P-1:0]    rs1_data_q, rs1_data_d;
    logic [DATA_WIDTH_P-1:0]    rs2_data_q, rs2_data_d;

    logic accept_c;
    logic hit1_c;
    logic hit2_c;

    assign o_ready  = (state_q == ST_IDLE) || ((state_q == ST_OUT) && i_ready);
    assign accept_c = i_valid && o_ready;

    // A writeback to a nonzero source index supersedes register-file data.
    assign hit1_c = i_wb_valid && (rs1_q != '0) && (i_wb_addr == rs1_q);
    assign hit2_c = i_wb_valid && (rs2_q != '0) && (i_wb_addr == rs2_q);

    always_comb begin
        state_d    = state_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        payload_d  = payload_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;

        if (accept_c) begin
            rs1_d     = i_rs1_addr;
            rs2_d     = i_rs2_addr;
            rd_d      = i_rd_addr;
            payload_d = i_payload;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_c) state_d = ST_ISSUE;
            end
            // The read register ignores write edges, so the read is simply retried.
            ST_ISSUE: begin
                if (!i_wb_valid) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_d = ST_OUT;
                if (rs1_q == '0)  rs1_data_d = '0;
                else if (hit1_c)  rs1_data_d = i_wb_data;
                else              rs1_data_d = i_rf_rd_data_a;
                if (rs2_q == '0)  rs2_data_d = '0;
                else if (hit2_c)  rs2_data_d = i_wb_data;
                else              rs2_data_d = i_rf_rd_data_b;
            end
            ST_OUT: begin
                if (i_ready) begin
                    state_d = accept_c ? ST_ISSUE : ST_IDLE;
                end else begin
                    if (hit1_c) rs1_data_d = i_wb_data;
                    if (hit2_c) rs2_data_d = i_wb_data;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            payload_q  <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            payload_q  <= payload_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
        end
    end

    assign o_valid        = (state_q == ST_OUT);
    assign o_rf_rd_addr_a = rs1_q;
    assign o_rf_rd_addr_b = rs2_q;
    assign o_rs1_data     = rs1_data_q;
    assign o_rs2_data     = rs2_data_q;
    assign o_rd_addr      = rd_q;
    assign o_payload      = payload_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios then random traffic, checked against
// a transaction-level model of latency and architectural register values.
module tb_operand_fetch;

    logic        clk;
    logic        reset;
    logic        i_valid;
    logic        o_ready;
    logic [4:0]  i_rs1_addr, i_rs2_addr, i_rd_addr;
    logic [31:0] i_payload;
    logic [4:0]  o_rf_rd_addr_a, o_rf_rd_addr_b;
    logic [31:0] i_rf_rd_data_a, i_rf_rd_data_b;
    logic        i_wb_valid;
    logic [4:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_rs1_data, o_rs2_data;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_payload;

    logic        rf_init;
    logic [31:0] mem [32];

    int vectors = 0;
    int errors  = 0;

    // model of the single in-flight instruction
    bit          have_req;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [31:0] m_pl;
    int          edges, stalls;
    bit          stall_done;

    operand_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_rs1_addr     (i_rs1_addr),
        .i_rs2_addr     (i_rs2_addr),
        .i_rd_addr      (i_rd_addr),
        .i_payload      (i_payload),
        .o_rf_rd_addr_a (o_rf_rd_addr_a),
        .o_rf_rd_addr_b (o_rf_rd_addr_b),
        .i_rf_rd_data_a (i_rf_rd_data_a),
        .i_rf_rd_data_b (i_rf_rd_data_b),
        .i_wb_valid     (i_wb_valid),
        .i_wb_addr      (i_wb_addr),
        .i_wb_data      (i_wb_data),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_rs1_data     (o_rs1_data),
        .o_rs2_data     (o_rs2_data),
        .o_rd_addr      (o_rd_addr),
        .o_payload      (o_payload)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file environment: registered read, read register frozen on write edges.
    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h1000 + 32'(i);
        end else if (i_wb_valid) begin
            mem[i_wb_addr] <= i_wb_data;
        end else begin
            i_rf_rd_data_a <= mem[o_rf_rd_addr_a];
            i_rf_rd_data_b <= mem[o_rf_rd_addr_b];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] arch(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : mem[a];
    endfunction

    function automatic bit exp_valid();
        return have_req && stall_done && (edges >= stalls + 2);
    endfunction

    function automatic bit exp_ready();
        return !have_req || (exp_valid() && i_ready);
    endfunction

    // One clock: check handshake readiness, advance the model over the edge, check outputs.
    task automatic step();
        bit pre_valid, pre_acc, pre_con, pre_wb;
        logic [4:0]  n_rs1, n_rs2, n_rd;
        logic [31:0] n_pl;
        #1;
        check("o_ready", 64'(o_ready), 64'(exp_ready()));
        pre_valid = exp_valid();
        pre_con   = pre_valid && i_ready;
        pre_acc   = i_valid && exp_ready();
        pre_wb    = i_wb_valid;
        n_rs1 = i_rs1_addr; n_rs2 = i_rs2_addr; n_rd = i_rd_addr; n_pl = i_payload;
        @(posedge clk);
        #1;
        if (pre_con) begin
            have_req = 1'b0;
        end else if (have_req && !pre_valid) begin
            edges++;
            if (!stall_done) begin
                if (pre_wb) stalls++;
                else        stall_done = 1'b1;
            end
        end
        if (pre_acc) begin
            have_req = 1'b1;
            m_rs1 = n_rs1; m_rs2 = n_rs2; m_rd = n_rd; m_pl = n_pl;
            edges = 0; stalls = 0; stall_done = 1'b0;
        end
        check("o_valid", 64'(o_valid), 64'(exp_valid()));
        if (have_req) begin
            check("rf_addr_a", 64'(o_rf_rd_addr_a), 64'(m_rs1));
            check("rf_addr_b", 64'(o_rf_rd_addr_b), 64'(m_rs2));
        end
        if (exp_valid()) begin
            check("rs1_data", 64'(o_rs1_data), 64'(arch(m_rs1)));
            check("rs2_data", 64'(o_rs2_data), 64'(arch(m_rs2)));
            check("rd_addr",  64'(o_rd_addr),  64'(m_rd));
            check("payload",  64'(o_payload),  64'(m_pl));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},   64'(o_valid),        64'(0));
        check({tag, "_ready"},   64'(o_ready),        64'(1));
        check({tag, "_rs1"},     64'(o_rs1_data),     64'(0));
        check({tag, "_rs2"},     64'(o_rs2_data),     64'(0));
        check({tag, "_rd"},      64'(o_rd_addr),      64'(0));
        check({tag, "_payload"}, 64'(o_payload),      64'(0));
        check({tag, "_rfa"},     64'(o_rf_rd_addr_a), 64'(0));
        check({tag, "_rfb"},     64'(o_rf_rd_addr_b), 64'(0));
    endtask

    task automatic mid_reset(input string tag);
        #3;
        reset = 1'b1;
        #1;
        check_reset_outputs(tag);
        have_req = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
    endtask

    task automatic set_req(input bit v, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [4:0] rd, input logic [31:0] pl);
        i_valid = v; i_rs1_addr = r1; i_rs2_addr = r2; i_rd_addr = rd; i_payload = pl;
    endtask

    task automatic set_wb(input bit v, input logic [4:0] a, input logic [31:0] d);
        i_wb_valid = v; i_wb_addr = a; i_wb_data = d;
    endtask

    initial begin
        reset = 1'b1; rf_init = 1'b1; i_ready = 1'b1;
        have_req = 1'b0; edges = 0; stalls = 0; stall_done = 1'b0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_pl = '0;
        set_req(1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        set_wb(1'b0, 5'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        #1;
        rf_init = 1'b0;
        reset   = 1'b0;

        // preload x5/x6
        set_wb(1'b1, 5'd5, 32'h11); step();
        set_wb(1'b1, 5'd6, 32'h22); step();
        set_wb(1'b0, 5'd0, 32'd0);

        // basic fetch, two edges of latency after accept
        set_req(1'b1, 5'd5, 5'd6, 5'd7, 32'hA); step();
        set_req(1'b0, 5'd0, 5'd0, 5'd0, 32'd0); step();
        check("basic_not_yet", 64'(o_valid), 64'(0));
        step();
        check("basic_valid", 64'(o_valid), 64'(1));
        check("basic_rs1", 64'(o_rs1_data), 64'(32'h11));
        check("basic_rs2", 64'(o_rs2_data), 64'(32'h22));
        check("basic_rd",  64'(o_rd_addr),  64'(7));
        check("basic_pl",  64'(o_payload),  64'(32'hA));
        step();

        // writes during ISSUE stall the fetch
        set_req(1'b1, 5'd5, 5'd6, 5'd1, 32'hB); step();
        set_req(1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        set_wb(1'b1, 5'd5, 32'h99); step(); step();
        set_wb(1'b0, 5'd0, 32'd0); step();
        check("stall_not_yet", 64'(o_valid), 64'(0));
        step();
        check("stall_valid", 64'(o_valid), 64'(1));
        check("stall_rs1", 64'(o_rs1_data), 64'(32'h99));
        step();

        // write during CAPTURE is bypassed
        set_req(1'b1, 5'd5, 5'd6, 5'd2, 32'hC); step();
        set_req(1'b0, 5'd0, 5'd0, 5'd0, 32'd0); step();
        set_wb(1'b1, 5'd5, 32'h77); step();
        set_wb(1'b0, 5'd0, 32'd0);
        check("bypass_rs1", 64'(o_rs1_data), 64'(32'h77));
        step();

        // held operands follow writebacks; x0 writes are ignored
        i_ready = 1'b0;
        set_req(1'b1, 5'd5, 5'd6, 5'd3, 32'hD); step();
        set_req(1'b0, 5'd0, 5'd0, 5'd0, 32'd0); step(); step();
        set_wb(1'b1, 5'd6, 32'h55); step();
        check("hold_rs2", 64'(o_rs2_data), 64'(32'h55));
        check("hold_rs1", 64'(o_rs1_data), 64'(32'h77));
        set_wb(1'b1, 5'd0, 32'hFF); step();
        check("hold_x0_rs2", 64'(o_rs2_data), 64'(32'h55));
        check("hold_x0_rs1", 64'(o_rs1_data), 64'(32'h77));
        set_wb(1'b0, 5'd0, 32'd0);
        i_ready = 1'b1; step();

        // x0 reads as zero regardless of register-file contents or bypass
        set_wb(1'b1, 5'd0, 32'hDEAD); step();
        set_wb(1'b0, 5'd0, 32'd0);
        set_req(1'b1, 5'd0, 5'd0, 5'd4, 32'hE); step();
        set_req(1'b0, 5'd0, 5'd0, 5'd0, 32'd0); step();
        set_wb(1'b1, 5'd0, 32'hBEEF); step();
        set_wb(1'b0, 5'd0, 32'd0);
        check("x0_rs1", 64'(o_rs1_data), 64'(0));
        check("x0_rs2", 64'(o_rs2_data), 64'(0));
        step();

        // reset while in ISSUE discards the request
        set_req(1'b1, 5'd5, 5'd6, 5'd9, 32'hF); step();
        set_req(1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        mid_reset("midreset");
        repeat (4) step();
        set_req(1'b1, 5'd5, 5'd6, 5'd8, 32'h12); step();
        set_req(1'b0, 5'd0, 5'd0, 5'd0, 32'd0); step(); step();
        check("after_reset_valid", 64'(o_valid), 64'(1));
        check("after_reset_rs1", 64'(o_rs1_data), 64'(32'h77));
        check("after_reset_rs2", 64'(o_rs2_data), 64'(32'h55));
        check("after_reset_rd",  64'(o_rd_addr),  64'(8));
        step();

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            set_req(($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), $urandom);
            i_ready = ($urandom_range(0, 9) < 6);
            set_wb(($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)), $urandom);
            if (n == 800) mid_reset("randreset");
            step();
        end

        set_req(1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        set_wb(1'b0, 5'd0, 32'd0);
        i_ready = 1'b1;
        repeat (8) step();
        check("drained", 64'(have_req), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
